// File: rtl/comb_vec_seq.sv
// Stimulus/capture sequencer for a 4-input combinational block: walks a fixed
// 16-vector ROM, holds each vector HOLD cycles and captures Y into a truth table.
module comb_vec_seq #(
  parameter int unsigned HOLD = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [3:0]  vec_idx,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] LAST = 8'(HOLD - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  abcd_q, abcd_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  ones_q, ones_d;

  // Ordered by weight: all-zero, single ones, pairs, triples, all-ones.
  function automatic logic [3:0] rom(input logic [3:0] i);
    case (i)
      4'd0:  rom = 4'b0000;
      4'd1:  rom = 4'b0001;
      4'd2:  rom = 4'b0010;
      4'd3:  rom = 4'b0100;
      4'd4:  rom = 4'b1000;
      4'd5:  rom = 4'b0011;
      4'd6:  rom = 4'b0101;
      4'd7:  rom = 4'b1001;
      4'd8:  rom = 4'b0110;
      4'd9:  rom = 4'b1010;
      4'd10: rom = 4'b1100;
      4'd11: rom = 4'b0111;
      4'd12: rom = 4'b1011;
      4'd13: rom = 4'b1110;
      4'd14: rom = 4'b1101;
      default: rom = 4'b1111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    abcd_d  = abcd_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          cnt_d   = '0;
          idx_d   = '0;
          abcd_d  = rom(4'd0);
          tt_d    = '0;
          ones_d  = '0;
        end
      end
      DRIVE: begin
        // abort wins over a capture on the same edge
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          abcd_d  = '0;
        end else if (cnt_q == LAST) begin
          tt_d[rom(idx_q)] = y;
          ones_d = ones_q + {4'd0, y};
          cnt_d  = '0;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            idx_d   = '0;
            abcd_d  = '0;
          end else begin
            idx_d  = idx_q + 4'd1;
            abcd_d = rom(idx_q + 4'd1);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        abcd_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      abcd_q  <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      abcd_q  <= abcd_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  assign {a, b, c, d}  = abcd_q;
  assign busy          = (state_q == DRIVE);
  assign done          = (state_q == DONE);
  assign vec_idx       = idx_q;
  assign truth_table   = tt_q;
  assign ones_cnt      = ones_q;

endmodule

// File: tb/tb_comb_vec_seq.sv
// Directed bench: two sequencers (HOLD=10 and HOLD=2) driving a modelled
// comb_Y2 whose function is selected per run.
module tb_comb_vec_seq;

  logic clk = 1'b0;
  logic rst_n, start, abort, start2, abort2;
  logic a, b, c, d, busy, done, a2, b2, c2, d2, busy2, done2;
  logic y, y2;
  logic [3:0]  vec_idx, vec_idx2;
  logic [15:0] truth_table, truth_table2;
  logic [4:0]  ones_cnt, ones_cnt2;
  int ymode;
  int n_vec = 0;
  int n_err = 0;

  logic [3:0] ROM [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h9,
                           4'h6, 4'hA, 4'hC, 4'h7, 4'hB, 4'hE, 4'hD, 4'hF};

  always #5 clk = ~clk;

  always_comb begin
    case (ymode)
      0: y = a ^ b ^ c ^ d;
      1: y = a & b & c & d;
      2: y = ~(a | b | c | d);
      default: y = a;
    endcase
  end
  assign y2 = a2;

  comb_vec_seq #(.HOLD(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y(y),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .vec_idx(vec_idx),
    .truth_table(truth_table), .ones_cnt(ones_cnt));

  comb_vec_seq #(.HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .y(y2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .vec_idx(vec_idx2),
    .truth_table(truth_table2), .ones_cnt(ones_cnt2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] abcd_of(input bit sel);
    return sel ? {a2, b2, c2, d2} : {a, b, c, d};
  endfunction
  function automatic logic [3:0] idx_of(input bit sel);
    return sel ? vec_idx2 : vec_idx;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy2 : busy;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? done2 : done;
  endfunction
  function automatic logic [15:0] tt_of(input bit sel);
    return sel ? truth_table2 : truth_table;
  endfunction
  function automatic logic [4:0] ones_of(input bit sel);
    return sel ? ones_cnt2 : ones_cnt;
  endfunction

  // Full run; first busy cycle is cycle 1, so done must show in cycle 16*hold+1.
  task automatic run_seq(input bit sel, input int hold, input bit poke,
                         input logic [15:0] ett, input logic [4:0] eones);
    int bad = 0;
    if (sel) start2 = 1'b1; else start = 1'b1;
    tick;
    start = 1'b0; start2 = 1'b0;
    chk("start_clear", {11'd0, tt_of(sel), ones_of(sel)}, 0);
    for (int k = 0; k < 16; k++)
      for (int h = 0; h < hold; h++) begin
        if (abcd_of(sel) !== ROM[k] || idx_of(sel) !== 4'(k) ||
            busy_of(sel) !== 1'b1 || done_of(sel) !== 1'b0) bad++;
        start = poke && (h == 1);
        tick;
      end
    start = 1'b0;
    chk("seq_hold", bad, 0);
    chk("done_at_cycle", done_of(sel), 1);
    chk("done_state", {busy_of(sel), abcd_of(sel), idx_of(sel)}, 0);
    tick;
    chk("done_one_cycle", {busy_of(sel), done_of(sel)}, 0);
    chk("truth_table", tt_of(sel), ett);
    chk("ones_cnt", ones_of(sel), eones);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0; ymode = 0;
    tick; tick;
    chk("reset", {a, b, c, d, busy, done, vec_idx, truth_table, ones_cnt}, 0);
    rst_n = 1'b1;
    tick;

    ymode = 0; run_seq(0, 10, 0, 16'h6996, 5'd8);
    ymode = 1; run_seq(0, 10, 0, 16'h8000, 5'd1);
    tick; tick; tick;
    chk("idle_hold_tt", {truth_table, ones_cnt}, {16'h8000, 5'd1});
    ymode = 2; run_seq(0, 10, 1, 16'h0001, 5'd1);

    // abort on the capture edge of vector 5
    ymode = 0;
    start = 1'b1; tick; start = 1'b0;
    repeat (5 * 10 + 9) tick;
    chk("abort_at_idx", vec_idx, 5);
    abort = 1'b1; tick; abort = 1'b0;
    chk("abort_state", {a, b, c, d, busy, done, vec_idx}, 0);
    chk("abort_tt", truth_table, 16'h0116);
    chk("abort_ones", ones_cnt, 4);
    tick; tick;
    chk("abort_no_done", done, 0);

    // synchronous reset mid-run
    start = 1'b1; tick; start = 1'b0;
    repeat (9 * 10) tick;
    chk("rst_at_idx", vec_idx, 9);
    rst_n = 1'b0; tick; rst_n = 1'b1;
    chk("midrun_reset", {a, b, c, d, busy, done, vec_idx, truth_table, ones_cnt}, 0);
    tick;
    run_seq(0, 10, 0, 16'h6996, 5'd8);

    run_seq(1, 2, 0, 16'hFF00, 5'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
